instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Owns the program counter and the instruction-memory request handshake.
//  Sits directly upstream of the decode pipeline register.
//  Consumes the flow controller's redirect (load/pc) and stall_fetch, and
//  reports instruction_memory_busy back to it.
//  Delivers {valid, pc, instruction} to decode; one request outstanding at most.
// PARAMETERS
//  RESET_VECTOR   32'hBFC0_0000   first fetch address after reset
//  ADDR_W         32              address / PC width
// PORTS
//  clk                      in   1       clock; all state on rising edge
//  reset                    in   1       asynchronous, active-high reset
//  load                     in   1       redirect request from flow controller
//  target_pc                in   32      redirect address, valid with load
//  stall_fetch              in   1       hold PC and fetch outputs this cycle
//  imem_req                 out  1       memory request valid
//  imem_addr                out  32      request address (word aligned)
//  imem_ack                 in   1       request complete; imem_rdata valid this cycle
//  imem_rdata               in   32      instruction word
//  instruction_memory_busy  out  1       fetch cannot deliver this cycle
//  if_valid                 out  1       if_pc/if_instruction hold a live instruction
//  if_pc                    out  32      PC of delivered instruction
//  if_instruction           out  32      delivered instruction word
// BEHAVIOUR
//  Reset is asynchronous, active-high. While reset is high and on release:
//   state=IDLE, fetch_pc=RESET_VECTOR, hold buffer empty, imem_req=0,
//   if_valid=0, if_pc=0, if_instruction=0, busy=0.
//  FSM states: IDLE, REQ, DISCARD, HELD.
//   IDLE    : no request. Next cycle -> REQ at fetch_pc.
//   REQ     : imem_req=1, imem_addr=fetch_pc, held stable until imem_ack.
//     ack & !stall_fetch & !load -> data to if_*, fetch_pc+=4, stay REQ
//       (back-to-back requests; single-cycle memory gives 1 instr/cycle).
//     ack & stall_fetch & !load  -> data into hold buffer, fetch_pc+=4, -> HELD.
//     !ack & load                -> fetch_pc=target_pc, -> DISCARD.
//       An issued request is never withdrawn.
//     ack & load                 -> drop rdata, fetch_pc=target_pc, stay REQ.
//   DISCARD : imem_req=1, imem_addr=stale address; on ack drop rdata -> REQ.
//     A further load here overwrites fetch_pc with the newest target.
//   HELD    : imem_req=0. On !stall_fetch, buffer -> if_*, -> REQ.
//     load in HELD empties the buffer, fetch_pc=target_pc, -> REQ
//       once !stall_fetch.
//  Output regs: when stall_fetch=1, if_* hold their values regardless of load.
//   When stall_fetch=0 and no instruction is delivered, if_valid<=0.
//  load has priority over data for PC; stall_fetch has priority over load for if_*.
//  instruction_memory_busy = (REQ & !imem_ack) | DISCARD | IDLE.
//   Depends only on state and imem_ack, never on stall_fetch or load
//   (no combinational loop through the flow controller).
//  imem_addr[1:0] forced to 0. Misaligned target_pc is truncated.
//   Alignment exceptions are raised elsewhere.
//  fetch_pc + 4 wraps modulo 2^32 without error.
// STRUCTURE
//  Shared pkg fetch_pkg: fetch_state_t enum {IDLE,REQ,DISCARD,HELD},
//   RESET_VECTOR default constant.
//  Sub-module fetch_hold_buffer: one-entry {pc,instr} register with
//   load/clear/valid.
//  Top module keeps the FSM, PC register and output register.
// TESTING
//  1 Reset release, imem_ack tied 1 -> addr BFC00000,
//    then BFC00004, BFC00008 on consecutive cycles; if_valid=1 from cycle 2.
//  2 ack delayed 3 cycles -> imem_addr stable 4 cycles, busy=1 for 3 of them,
//    if_valid=0 until data.
//  3 load target 0x80000180 while REQ unacked -> DISCARD; stale rdata never
//    reaches if_*; next request addr 80000180.
//  4 stall_fetch=1 on ack cycle -> HELD, imem_req=0, if_* unchanged.
//    On release the buffered instruction appears with correct pc.
//  5 load & stall_fetch same cycle while HELD -> buffer dropped, if_* hold.
//    After release, first request is target_pc.
//  6 Assert reset mid-REQ -> imem_req=0 and if_valid=0 immediately (async);
//    first post-reset addr BFC00000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam int          INSTR_W              = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD,
        HELD
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry {pc, instruction} buffer that parks a fetched word while decode is stalled.
module fetch_hold_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr
);

    // NOTE: the payload is reset as well as the valid bit; it is a single entry, and
    // a known value keeps X out of if_* even if valid is ever decoded incorrectly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_in;
            instr <= instr_in;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter, instruction-memory handshake and decode-facing output register.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [ADDR_W-1:0]  target_pc,
    input  logic               stall_fetch,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instruction_memory_busy,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instruction
);

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nx;
    logic [ADDR_W-1:0] stale_addr, stale_addr_nx;
    logic [ADDR_W-1:0] target_aligned;
    logic              buf_load, buf_clear, buf_valid;
    logic [ADDR_W-1:0] buf_pc;
    logic [INSTR_W-1:0] buf_instr;
    logic              deliver_mem, deliver_buf;

    assign target_aligned = target_pc & ~ADDR_W'(3);

    fetch_hold_buffer #(.ADDR_W(ADDR_W)) u_hold (
        .clk      (clk),
        .reset    (reset),
        .load     (buf_load),
        .clear    (buf_clear),
        .pc_in    (fetch_pc),
        .instr_in (imem_rdata),
        .valid    (buf_valid),
        .pc       (buf_pc),
        .instr    (buf_instr)
    );

    // NOTE: every signal gets a default before the case so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_nx      = state;
        fetch_pc_nx   = fetch_pc;
        stale_addr_nx = stale_addr;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        deliver_mem   = 1'b0;
        deliver_buf   = 1'b0;
        case (state)
            IDLE: begin
                state_nx = REQ;
                if (load) fetch_pc_nx = target_aligned;
            end
            REQ: begin
                if (load) begin
                    // A redirect always wins the PC; an unacked request must still complete.
                    fetch_pc_nx = target_aligned;
                    if (!imem_ack) begin
                        stale_addr_nx = fetch_pc;
                        state_nx      = DISCARD;
                    end
                end else if (imem_ack) begin
                    fetch_pc_nx = fetch_pc + ADDR_W'(4);
                    if (stall_fetch) begin
                        buf_load = 1'b1;
                        state_nx = HELD;
                    end else begin
                        deliver_mem = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (load)     fetch_pc_nx = target_aligned;
                if (imem_ack) state_nx    = REQ;
            end
            HELD: begin
                if (load) begin
                    fetch_pc_nx = target_aligned;
                    buf_clear   = 1'b1;
                end
                if (!stall_fetch) begin
                    deliver_buf = buf_valid && !load;
                    buf_clear   = 1'b1;
                    state_nx    = REQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign imem_req  = (state == REQ) || (state == DISCARD);
    assign imem_addr = (state == DISCARD) ? stale_addr : fetch_pc;

    // Gated by reset so the flow controller sees an idle fetch while reset is held.
    assign instruction_memory_busy = !reset &&
        (((state == REQ) && !imem_ack) || (state == DISCARD) || (state == IDLE));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_VECTOR;
            stale_addr <= RESET_VECTOR;
        end else begin
            state      <= state_nx;
            fetch_pc   <= fetch_pc_nx;
            stale_addr <= stale_addr_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid       <= 1'b0;
            if_pc          <= '0;
            if_instruction <= '0;
        end else if (!stall_fetch) begin
            if_valid <= deliver_mem || deliver_buf;
            if (deliver_mem) begin
                if_pc          <= fetch_pc;
                if_instruction <= imem_rdata;
            end else if (deliver_buf) begin
                if_pc          <= buf_pc;
                if_instruction <= buf_instr;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] target_pc;
    logic        stall_fetch;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instruction_memory_busy;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;

    int tests = 0;
    int fails = 0;

    instruction_fetch_unit dut (
        .clk                     (clk),
        .reset                   (reset),
        .load                    (load),
        .target_pc               (target_pc),
        .stall_fetch             (stall_fetch),
        .imem_req                (imem_req),
        .imem_addr               (imem_addr),
        .imem_ack                (imem_ack),
        .imem_rdata              (imem_rdata),
        .instruction_memory_busy (instruction_memory_busy),
        .if_valid                (if_valid),
        .if_pc                   (if_pc),
        .if_instruction          (if_instruction)
    );

    always #5 clk = ~clk;

    // Reference model: a request is in flight whenever fetch is warmed up and not
    // parked waiting for decode; a request overtaken by a redirect is "doomed".
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    bit          m_warm, m_paused, m_doomed;
    logic [31:0] m_pc, m_doomed_addr;
    entry_t      m_held[$];
    logic        m_out_valid;
    logic [31:0] m_out_pc, m_out_instr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        m_warm      = 0;
        m_paused    = 0;
        m_doomed    = 0;
        m_pc        = 32'hBFC0_0000;
        m_held.delete();
        m_out_valid = 0;
        m_out_pc    = 0;
        m_out_instr = 0;
    endtask

    task automatic check_outputs();
        logic        exp_req;
        logic [31:0] exp_addr;
        exp_req  = m_warm && !m_paused;
        exp_addr = m_doomed ? m_doomed_addr : m_pc;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, exp_addr);
        check("busy", 32'(instruction_memory_busy),
              32'(!m_warm || (exp_req && (m_doomed || !imem_ack))));
        check("if_valid", 32'(if_valid), 32'(m_out_valid));
        if (m_out_valid) begin
            check("if_pc", if_pc, m_out_pc);
            check("if_instruction", if_instruction, m_out_instr);
        end
    endtask

    task automatic model_clock();
        bit     have;
        entry_t d;
        have = 0;
        d    = '{pc: 32'h0, instr: 32'h0};
        if (!m_warm) begin
            m_warm = 1;
            if (load) m_pc = align(target_pc);
        end else if (m_paused) begin
            if (load) begin
                m_held.delete();
                m_pc = align(target_pc);
            end
            if (!stall_fetch) begin
                m_paused = 0;
                if (m_held.size() > 0) begin
                    d    = m_held.pop_front();
                    have = 1;
                end
            end
        end else if (m_doomed) begin
            if (load) m_pc = align(target_pc);
            if (imem_ack) m_doomed = 0;
        end else if (imem_ack) begin
            if (load) begin
                m_pc = align(target_pc);
            end else if (stall_fetch) begin
                m_held.push_back('{pc: m_pc, instr: imem_rdata});
                m_pc     = m_pc + 32'd4;
                m_paused = 1;
            end else begin
                d    = '{pc: m_pc, instr: imem_rdata};
                have = 1;
                m_pc = m_pc + 32'd4;
            end
        end else if (load) begin
            m_doomed_addr = m_pc;
            m_doomed      = 1;
            m_pc          = align(target_pc);
        end
        if (!stall_fetch) begin
            m_out_valid = have;
            if (have) begin
                m_out_pc    = d.pc;
                m_out_instr = d.instr;
            end
        end
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic step(input logic ld, input logic [31:0] tgt, input logic st,
                        input logic ak);
        load        = ld;
        target_pc   = tgt;
        stall_fetch = st;
        imem_ack    = ak;
        imem_rdata  = $urandom;
        #1;
        check_outputs();
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n, input logic ak);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, ak);
    endtask

    initial begin
        reset       = 1'b1;
        load        = 1'b0;
        target_pc   = 32'h0;
        stall_fetch = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_busy", 32'(instruction_memory_busy), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instruction, 32'd0);

        // 1: ack tied high streams one instruction per cycle from the reset vector
        reset = 1'b0;
        idle_steps(2, 1'b1);
        check("t1_addr", imem_addr, 32'hBFC0_0004);
        idle_steps(4, 1'b1);

        // 2: slow memory holds the address while busy
        idle_steps(3, 1'b0);
        idle_steps(2, 1'b1);

        // 3: redirect while unacked discards the in-flight word
        step(1'b1, 32'h8000_0180, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("t3_addr", imem_addr, 32'h8000_0180);
        idle_steps(2, 1'b1);

        // 4: stall on ack parks the instruction, released later
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        idle_steps(2, 1'b1);

        // 5: load with stall while parked drops the buffer
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_1003, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        idle_steps(2, 1'b1);

        // PC wrap at the top of the address space
        step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        idle_steps(3, 1'b1);

        // 6: asynchronous reset in the middle of a request
        step(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_req", 32'(imem_req), 32'd0);
        check("t6_valid", 32'(if_valid), 32'd0);
        check("t6_busy", 32'(instruction_memory_busy), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("t6_addr", imem_addr, 32'hBFC0_0000);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(($urandom_range(0, 7) == 0), tgt, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
